// File: rtl/max11046_seq_ctrl_pkg.sv
// Shared types and default timing for the MAX11046 sequencer: FSM state enum,
// channel index width and the default cycle counts.
package max11046_pkg;
  localparam int CH_W               = 3;
  localparam int DEF_CONV_PERIOD    = 2000;
  localparam int DEF_NUM_CH         = 8;
  localparam int DEF_CONVST_LOW_CYC = 4;
  localparam int DEF_CS_SETUP_CYC   = 2;
  localparam int DEF_RD_LOW_CYC     = 4;
  localparam int DEF_RD_HIGH_CYC    = 2;
  localparam int DEF_TIMEOUT_CYC    = 1024;

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_EOC, CS_SETUP, RD_LOW, RD_HIGH, DONE
  } seq_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/max11046_seq_ctrl_if.sv
// ADC pin bundle plus the tagged sample stream; master is the sequencer side.
interface max11046_seq_ctrl_if;
  import max11046_pkg::*;

  logic            eoc_n;
  logic [15:0]     db_in;
  logic            convst_n;
  logic            cs_n;
  logic            rd_n;
  logic            wr_n;
  logic [15:0]     sample_data;
  logic [CH_W-1:0] sample_ch;
  logic            sample_valid;
  logic            sample_ready;

  modport master (
    input  eoc_n, db_in, sample_ready,
    output convst_n, cs_n, rd_n, wr_n, sample_data, sample_ch, sample_valid
  );

  modport slave (
    output eoc_n, db_in, sample_ready,
    input  convst_n, cs_n, rd_n, wr_n, sample_data, sample_ch, sample_valid
  );
endinterface

// File: rtl/max11046_seq_ctrl_eoc_sync.sv
// Two-flop synchronizer for the asynchronous EOC line with a falling-edge pulse
// taken from the synchronized copy; all flops idle high.
module max11046_eoc_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic eoc_n_i,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], eoc_n_i};
      prev_q <= sync_q[1];
    end
  end

  assign fall_o = prev_q & ~sync_q[1];
endmodule

// File: rtl/max11046_seq_ctrl.sv
// MAX11046 frame sequencer: periodic CONVST, EOC wait, timed CS/RD reads, sample stream.
// Optional EOC watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module max11046_seq_ctrl
  import max11046_pkg::*;
#(
  parameter int CONV_PERIOD    = DEF_CONV_PERIOD,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CONVST_LOW_CYC = DEF_CONVST_LOW_CYC,
  parameter int CS_SETUP_CYC   = DEF_CS_SETUP_CYC,
  parameter int RD_LOW_CYC     = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC    = DEF_RD_HIGH_CYC
`ifdef ADC_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
`endif
) (
  input  logic clock1,
  input  logic reset_n,
  input  logic enable,
  input  logic clr_flags,
  max11046_seq_ctrl_if.master io,
  output logic frame_done,
  output logic overrun,
  output logic trig_miss,
  output logic timeout_err
);
  localparam int MAX_CYC = max4(CONVST_LOW_CYC, CS_SETUP_CYC, RD_LOW_CYC, RD_HIGH_CYC);
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PER_W   = $clog2(CONV_PERIOD);
  localparam logic [TMR_W-1:0] LD_CONV = TMR_W'(CONVST_LOW_CYC - 1);
  localparam logic [TMR_W-1:0] LD_CS   = TMR_W'(CS_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_RDL  = TMR_W'(RD_LOW_CYC - 1);
  localparam logic [TMR_W-1:0] LD_RDH  = TMR_W'(RD_HIGH_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CONV_PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  seq_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             trig, eoc_fall, capture;
  logic             convst_n_q, cs_n_q, rd_n_q, frame_done_q, trig_miss_q;
  logic             overrun_q, sample_valid_q;
  logic [15:0]      sample_data_q;
  logic [CH_W-1:0]  sample_ch_q;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tout, timeout_q;
`endif

  max11046_eoc_sync u_eoc_sync (
    .clk_i   (clock1),
    .rst_ni  (reset_n),
    .eoc_n_i (io.eoc_n),
    .fall_o  (eoc_fall)
  );

  assign trig = enable && (per_q == PER_LAST);

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    ch_d    = ch_q;
    capture = 1'b0;
    per_d   = (!enable || per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
`ifdef ADC_SEQ_TIMEOUT_EN
    tout    = 1'b0;
    wait_d  = (state_q == WAIT_EOC) ? wait_q + WAIT_W'(1) : '0;
`endif
    case (state_q)
      IDLE: if (trig) begin
        state_d = CONV;
        tmr_d   = LD_CONV;
      end
      CONV: if (tmr_q == '0) state_d = WAIT_EOC;
      WAIT_EOC: begin
        if (eoc_fall) begin
          state_d = CS_SETUP;
          tmr_d   = LD_CS;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          tout    = 1'b1;
        end
`endif
      end
      CS_SETUP: if (tmr_q == '0) begin
        state_d = RD_LOW;
        tmr_d   = LD_RDL;
      end
      RD_LOW: if (tmr_q == '0) begin
        capture = 1'b1;
        if (ch_q == CH_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RD_HIGH;
          tmr_d   = LD_RDH;
        end
      end
      RD_HIGH: if (tmr_q == '0) begin
        state_d = RD_LOW;
        tmr_d   = LD_RDL;
        ch_d    = ch_q + CH_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow the next state so each one is a register aligned to its state;
  // cs_n is still low during DONE and rises with the frame_done pulse.
  always_ff @(posedge clock1) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      ch_q         <= '0;
      per_q        <= '0;
      convst_n_q   <= 1'b1;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      trig_miss_q  <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      wait_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      ch_q         <= ch_d;
      per_q        <= per_d;
      convst_n_q   <= (state_d != CONV);
      cs_n_q       <= !(state_d inside {CS_SETUP, RD_LOW, RD_HIGH, DONE});
      rd_n_q       <= (state_d != RD_LOW);
      frame_done_q <= (state_q == DONE);
      if (trig && state_q != IDLE) trig_miss_q <= 1'b1;
      else if (clr_flags)          trig_miss_q <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      wait_q       <= wait_d;
      timeout_q    <= tout;
`endif
    end
  end

  always_ff @(posedge clock1) begin
    if (!reset_n) begin
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      if (capture && (!sample_valid_q || io.sample_ready)) begin
        sample_valid_q <= 1'b1;
        sample_data_q  <= io.db_in;
        sample_ch_q    <= ch_q;
      end else if (sample_valid_q && io.sample_ready) begin
        sample_valid_q <= 1'b0;
      end
      if (capture && sample_valid_q && !io.sample_ready) overrun_q <= 1'b1;
      else if (clr_flags)                                 overrun_q <= 1'b0;
    end
  end

  assign io.convst_n     = convst_n_q;
  assign io.cs_n         = cs_n_q;
  assign io.rd_n         = rd_n_q;
  assign io.wr_n         = 1'b1;
  assign io.sample_data  = sample_data_q;
  assign io.sample_ch    = sample_ch_q;
  assign io.sample_valid = sample_valid_q;
  assign frame_done      = frame_done_q;
  assign overrun         = overrun_q;
  assign trig_miss       = trig_miss_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign timeout_err     = timeout_q;
`else
  assign timeout_err     = 1'b0;
`endif
endmodule

// File: tb/tb_max11046_seq_ctrl.sv
// Bench for max11046_seq_ctrl: ADC model (EOC delay, per-read data pattern), stream
// monitor, table of frame scenarios plus reset / enable-drop / timeout sequences.
module tb_max11046_seq_ctrl;
  import max11046_pkg::*;

  localparam int PERIOD = 128;
  localparam int CS_LEN = 2 + 8 * 4 + 7 * 2 + 1;

  logic clock1 = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clr_flags = 1'b0;
  logic frame_done, overrun, trig_miss, timeout_err;
  logic eoc_drv = 1'b1;
  logic [15:0] db_drv = 16'h0000;
  logic ready = 1'b1;

  max11046_seq_ctrl_if io();
  assign io.eoc_n = eoc_drv;
  assign io.db_in = db_drv;
  assign io.sample_ready = ready;

  always #5 clock1 = ~clock1;

  max11046_seq_ctrl #(
    .CONV_PERIOD(PERIOD), .NUM_CH(8)
`ifdef ADC_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clock1(clock1), .reset_n(reset_n), .enable(enable), .clr_flags(clr_flags),
    .io(io), .frame_done(frame_done), .overrun(overrun),
    .trig_miss(trig_miss), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_word(input int f, input int ch);
    return 16'((f * 305) ^ (ch * 4369) ^ 42435);
  endfunction

  // ADC model: data word per RD falling edge, EOC pulse a set delay after CONVST.
  int frame_cnt = 0;
  int rd_idx = 0;
  int eoc_delay = 50;
  bit eoc_en = 1'b1;
  int eoc_lat = 0;

  always @(negedge io.cs_n) begin
    frame_cnt++;
    rd_idx = 0;
  end

  always @(negedge io.rd_n) begin
    db_drv = mk_word(frame_cnt, rd_idx);
    rd_idx++;
  end

  always begin
    @(negedge io.convst_n);
    if (eoc_en) begin
      repeat (eoc_delay) @(posedge clock1);
      #1 eoc_drv = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clock1);
        #1;
        if (k == 5) eoc_drv = 1'b1;
        if (!io.cs_n && eoc_lat == 0) eoc_lat = k;
      end
    end
  end

  // Stream and strobe monitor.
  logic [15:0] q_data[$];
  logic [2:0]  q_ch[$];
  int conv_falls = 0, conv_len = 0, conv_cur = 0;
  int cs_falls = 0, cs_len = 0, cs_cur = 0;
  int fd_cnt = 0, to_cnt = 0;
  logic conv_prev = 1'b1, cs_prev = 1'b1;

  always @(negedge clock1) begin
    if (io.sample_valid === 1'b1 && io.sample_ready === 1'b1) begin
      q_data.push_back(io.sample_data);
      q_ch.push_back(io.sample_ch);
      $display("word ch=%0d data=%h", io.sample_ch, io.sample_data);
    end
    if (io.convst_n === 1'b0) begin
      if (conv_prev) begin conv_falls++; conv_cur = 1; end
      else conv_cur++;
    end else if (!conv_prev) conv_len = conv_cur;
    conv_prev = (io.convst_n !== 1'b0);
    if (io.cs_n === 1'b0) begin
      if (cs_prev) begin cs_falls++; cs_cur = 1; end
      else cs_cur++;
    end else if (!cs_prev) cs_len = cs_cur;
    cs_prev = (io.cs_n !== 1'b0);
    if (frame_done === 1'b1) fd_cnt++;
    if (timeout_err !== 1'b0) to_cnt++;
  end

  task automatic clear_stats();
    @(posedge clock1);
    #1;
    q_data.delete();
    q_ch.delete();
    conv_falls = 0; conv_len = 0; cs_falls = 0; cs_len = 0;
    fd_cnt = 0; eoc_lat = 0;
  endtask

  task automatic quiet();
    enable = 1'b0;
    ready = 1'b1;
    repeat (30) @(posedge clock1);
    #1;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      @(posedge clock1);
      #1;
      n++;
    end
    chk({name, "_reached"}, frame_done, 1);
  endtask

  task automatic wait_rd(input string name, input int idx);
    int n = 0;
    while (rd_idx != idx && n < 1000) begin
      @(posedge clock1);
      #1;
      n++;
    end
    chk({name, "_rd_reached"}, rd_idx, idx);
  endtask

  task automatic chk_words(input string name, input int nexp);
    chk({name, "_words"}, q_data.size(), nexp);
    for (int i = 0; i < q_data.size() && i < nexp; i++) begin
      chk($sformatf("%s_ch%0d", name, i), q_ch[i], i);
      chk($sformatf("%s_data%0d", name, i), q_data[i], mk_word(frame_cnt, i));
    end
  endtask

  typedef struct {
    int delay;
    bit rdy;
    int words;
    bit ovr;
    bit tmiss;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{50, 1'b1, 8, 1'b0, 1'b0};
    vecs[1] = '{20, 1'b1, 8, 1'b0, 1'b0};
    vecs[2] = '{50, 1'b0, 0, 1'b1, 1'b0};
    vecs[3] = '{90, 1'b1, 8, 1'b0, 1'b1};

    repeat (3) @(negedge clock1);
    chk("rst_convst_n", io.convst_n, 1);
    chk("rst_cs_n", io.cs_n, 1);
    chk("rst_rd_n", io.rd_n, 1);
    chk("rst_wr_n", io.wr_n, 1);
    chk("rst_valid", io.sample_valid, 0);
    chk("rst_data", io.sample_data, 0);
    chk("rst_ch", io.sample_ch, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_trig_miss", trig_miss, 0);
    chk("rst_timeout", timeout_err, 0);
    @(posedge clock1);
    #1 reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      quiet();
      clear_stats();
      eoc_delay = vecs[v].delay;
      ready = vecs[v].rdy;
      enable = 1'b1;
      wait_frame($sformatf("v%0d", v));
      enable = 1'b0;
      repeat (3) @(posedge clock1);
      #1;
      chk_words($sformatf("v%0d", v), vecs[v].words);
      chk($sformatf("v%0d_frame_done_cnt", v), fd_cnt, 1);
      chk($sformatf("v%0d_cs_len", v), cs_len, CS_LEN);
      chk($sformatf("v%0d_convst_len", v), conv_len, 4);
      chk($sformatf("v%0d_convst_cnt", v), conv_falls, 1);
      chk($sformatf("v%0d_eoc_to_cs", v), eoc_lat, 3);
      chk($sformatf("v%0d_overrun", v), overrun, vecs[v].ovr);
      chk($sformatf("v%0d_trig_miss", v), trig_miss, vecs[v].tmiss);
      if (!vecs[v].rdy) begin
        chk($sformatf("v%0d_held_valid", v), io.sample_valid, 1);
        chk($sformatf("v%0d_held_ch", v), io.sample_ch, 0);
        chk($sformatf("v%0d_held_data", v), io.sample_data, mk_word(frame_cnt, 0));
      end
      @(negedge clock1) clr_flags = 1'b1;
      @(negedge clock1) clr_flags = 1'b0;
      chk($sformatf("v%0d_clr_overrun", v), overrun, 0);
      chk($sformatf("v%0d_clr_trig_miss", v), trig_miss, 0);
    end

    // Reset while channel 3 is being read.
    quiet();
    clear_stats();
    eoc_delay = 50;
    enable = 1'b1;
    wait_rd("rst_mid", 4);
    chk("rst_mid_rd_low", io.rd_n, 0);
    reset_n = 1'b0;
    @(posedge clock1);
    #1;
    chk("rst_mid_cs_n", io.cs_n, 1);
    chk("rst_mid_rd_n", io.rd_n, 1);
    chk("rst_mid_valid", io.sample_valid, 0);
    chk("rst_mid_convst_n", io.convst_n, 1);
    repeat (2) @(posedge clock1);
    clear_stats();
    reset_n = 1'b1;
    wait_frame("rst_after");
    enable = 1'b0;
    repeat (3) @(posedge clock1);
    #1;
    chk_words("rst_after", 8);
    chk("rst_after_cs_len", cs_len, CS_LEN);
    chk("rst_after_frame_done_cnt", fd_cnt, 1);

    // Enable dropped during channel 5.
    quiet();
    clear_stats();
    enable = 1'b1;
    wait_rd("en_drop", 6);
    enable = 1'b0;
    wait_frame("en_drop");
    repeat (3) @(posedge clock1);
    #1;
    chk_words("en_drop", 8);
    chk("en_drop_frame_done_cnt", fd_cnt, 1);
    repeat (300) @(posedge clock1);
    #1;
    chk("en_drop_no_more_convst", conv_falls, 1);

`ifdef ADC_SEQ_TIMEOUT_EN
    begin
      int n;
      quiet();
      clear_stats();
      eoc_en = 1'b0;
      enable = 1'b1;
      n = 0;
      while (io.convst_n !== 1'b0 && n < 300) begin @(posedge clock1); #1; n++; end
      n = 0;
      while (io.convst_n !== 1'b1 && n < 300) begin @(posedge clock1); #1; n++; end
      n = 0;
      while (timeout_err !== 1'b1 && n < 300) begin @(posedge clock1); #1; n++; end
      chk("timeout_cycles", n, 100);
      @(posedge clock1);
      #1;
      chk("timeout_pulse_width", timeout_err, 0);
      enable = 1'b0;
      chk("timeout_no_cs", cs_falls, 0);
      chk("timeout_no_words", q_data.size(), 0);
      chk("timeout_no_valid", io.sample_valid, 0);
      eoc_en = 1'b1;
    end
`else
    chk("timeout_err_never", to_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/max11046_seq_ctrl.md
# max11046_seq_ctrl

Synchronous sequencer for the MAX11046 8-channel 16-bit parallel ADC, clocked from the fabric clock. Per frame it:
- generates periodic CONVST pulses from a programmable divider,
- waits for end-of-conversion,
- reads the selected channels with timed CS/RD strobes,
- hands each word downstream on a valid/ready stream with channel tag.

It sits between the ADC pins and the force-measurement sample pipeline and replaces delay-based strobe generation with cycle-counted timing.

## Interface
Parameters:
- CONV_PERIOD, 2000: clocks between conversion triggers (min 64).
- NUM_CH, 8: channels read per frame (1..8), read in order 0..NUM_CH-1.
- CONVST_LOW_CYC, 4: CONVST low pulse width in clocks.
- CS_SETUP_CYC, 2: CS low to first RD low, in clocks.
- RD_LOW_CYC, 4: RD low width; data is sampled on the last low cycle.
- RD_HIGH_CYC, 2: RD high width between reads.
- TIMEOUT_CYC, 1024: EOC wait limit (only with timeout feature).

Ports:
- clock1  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  run conversions while high.
- eoc_n  in  1  ADC EOC, asynchronous, active-low.
- db_in  in  16  ADC data bus.
- convst_n  out  1  conversion start, active-low pulse.
- cs_n  out  1  chip select, active-low.
- rd_n  out  1  read strobe, active-low.
- wr_n  out  1  write strobe, constant 1.
- sample_data  out  16  captured word.
- sample_ch  out  3  channel index of sample_data.
- sample_valid  out  1  word available.
- sample_ready  in  1  consumer accepts word.
- frame_done  out  1  one-cycle pulse after last channel read.
- overrun  out  1  sticky: word dropped, consumer not ready.
- trig_miss  out  1  sticky: trigger arrived while not IDLE.
- clr_flags  in  1  clears overrun, trig_miss on next edge.
- timeout_err  out  1  one-cycle pulse on EOC timeout (feature-dependent).

## Operation
- eoc_n passes through a 2-flop synchronizer; the falling edge is detected on the synchronized copy.
- Period counter:
  - Counts 0..CONV_PERIOD-1 while enable=1; held at 0 while enable=0.
  - Issues a trigger on the cycle it wraps to 0.
- FSM states: IDLE, CONV, WAIT_EOC, CS_SETUP, RD_LOW, RD_HIGH, DONE.
  - IDLE: on trigger -> CONV.
  - CONV: convst_n=0 for CONVST_LOW_CYC cycles -> WAIT_EOC.
  - WAIT_EOC: on synchronized EOC fall -> CS_SETUP with cs_n=0.
  - CS_SETUP: CS_SETUP_CYC cycles -> RD_LOW.
  - RD_LOW: rd_n=0 for RD_LOW_CYC cycles; db_in is captured on the final cycle.
    - If ch<NUM_CH-1 -> RD_HIGH.
    - If ch=NUM_CH-1 -> DONE.
  - RD_HIGH: rd_n=1 for RD_HIGH_CYC cycles, ch increments -> RD_LOW.
  - DONE: cs_n=1, frame_done=1 for one cycle, ch=0 -> IDLE.
- Output register:
  - A capture loads sample_data/sample_ch and sets sample_valid.
  - sample_valid clears on the cycle where sample_valid & sample_ready.
  - Capture while sample_valid=1 and sample_ready=0: the new word is dropped, the held word is unchanged, overrun sets.
  - Capture on the same cycle as a handshake is accepted normally.
- A trigger in any state other than IDLE is ignored and sets trig_miss.
- Flags:
  - clr_flags and a set on the same cycle: set wins.
- Enable:
  - Deasserting enable mid-frame: the current frame completes, then the FSM stays in IDLE.
  - Re-assertion restarts the divider from 0.
- Reset mid-frame: all strobes go inactive on the next edge and the FSM returns to IDLE, with no partial-frame output.

## Timing
- Reset values: convst_n=1, cs_n=1, rd_n=1, wr_n=1, sample_valid=0, sample_data=0, sample_ch=0, frame_done=0, overrun=0, trig_miss=0, timeout_err=0.
- All outputs are registered; no combinational path from any input to any output.
- EOC fall to cs_n low: 3 clocks (2 synchronizer + 1 register).
- Capture to sample_valid high: 1 clock.
- Frame length from cs_n low to cs_n high: CS_SETUP_CYC + NUM_CH*RD_LOW_CYC + (NUM_CH-1)*RD_HIGH_CYC + 1.
- Down-counters are $clog2-sized to the largest parameter and reload on every state entry.

## Configuration
- ADC_SEQ_TIMEOUT_EN defined:
  - WAIT_EOC counts cycles; reaching TIMEOUT_CYC pulses timeout_err for one cycle and forces IDLE.
  - cs_n stays 1 and no samples are emitted for that frame.
- Not defined:
  - WAIT_EOC waits indefinitely.
  - timeout_err is tied to 0 and the TIMEOUT_CYC counter is not built.

## Structure
- Package max11046_pkg holds:
  - the FSM state enum (seq_state_t),
  - the default timing constants,
  - the channel index width (CH_W=3).
- One sub-module, max11046_eoc_sync: 2-flop synchronizer plus falling-edge pulse, with reset value 1.
- All else lives in a single always_ff FSM/counter block plus the output register.

## Test plan
- NUM_CH=8, model EOC falls 50 clocks after convst_n low, ready=1 -> 8 words with sample_ch 0..7 matching the model bus; one frame_done; convst_n low for exactly 4 clocks.
- sample_ready=0 for a whole frame -> channel 0 word is held valid, overrun=1; clr_flags -> overrun=0 next cycle.
- CONV_PERIOD=64 with an EOC delay so the frame exceeds 64 clocks -> trig_miss=1 and the next conversion starts only from IDLE.
- With ADC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, EOC never falls -> timeout_err pulses at 100 cycles, FSM returns to IDLE, no sample_valid.
- reset_n low during RD_LOW of channel 3 -> next edge: cs_n=rd_n=1, sample_valid=0, FSM in IDLE; after release, the first frame is complete.
- enable dropped during channel 5 read -> channels 5..7 still delivered, frame_done pulses, then no further convst_n.
